bcd_field_counter: RTL
======================

// Module: bcd_field_counter
// PURPOSE
//  Parametrised two-digit BCD time-field counter (seconds/minutes/hours) for the alarm clock.
//  Counts MIN_VAL..MAX_VAL with wrap, carry/borrow to the neighbouring field and validated parallel load.
//  Adds an auto-repeat adjust FSM: a held up/down button steps once, then repeats at a tick-paced rate.
//  One instance per field, chained seconds -> minutes -> hours through carry_out/count_inc.
// PARAMETERS
//  MAX_VAL       59  top of range, decimal (59 min/sec, 23 hours, 12 for 12-h hours)
//  MIN_VAL        0  bottom of range, decimal (1 for 12-h hours); MIN_VAL < MAX_VAL <= 99
//  HOLD_TICKS     8  tick_en pulses a button is held before auto-repeat starts (>=1)
//  REPEAT_TICKS   2  tick_en pulses between auto-repeat steps (>=1)
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  resetn     in   1  asynchronous active-low reset
//  count_inc  in   1  count-up request (1-cycle pulse; lower field carry or 1 Hz enable)
//  count_dec  in   1  count-down request (1-cycle pulse)
//  set_mode   in   1  1 = user adjust mode; gates count_inc/count_dec, enables adjust FSM
//  adj_up     in   1  debounced level, "up" button
//  adj_dn     in   1  debounced level, "down" button
//  tick_en    in   1  slow timebase pulse pacing auto-repeat (e.g. 8 Hz)
//  load       in   1  parallel load strobe
//  new_tens   in   4  BCD tens digit for load
//  new_ones   in   4  BCD ones digit for load
//  tens       out  4  BCD tens digit
//  ones       out  4  BCD ones digit
//  carry_out  out  1  1-cycle pulse when count_inc wraps MAX_VAL -> MIN_VAL
//  borrow_out out  1  1-cycle pulse when count_dec wraps MIN_VAL -> MAX_VAL
//  at_max     out  1  combinational, value == MAX_VAL
//  load_err   out  1  1-cycle pulse, load rejected
// BEHAVIOUR
//  Reset: value = MIN_VAL, carry_out/borrow_out/load_err = 0, FSM = IDLE, tick counter = 0.
//  Value update priority per cycle: load > adjust step > count_inc > count_dec.
//  Load: accepted iff both digits <= 9 and MIN_VAL <= 10*tens+ones <= MAX_VAL; value updates next edge.
//    Rejected load: value unchanged, load_err pulses 1 cycle. Load also resets FSM to IDLE.
//  Count (set_mode=0 only): inc at MAX_VAL -> MIN_VAL + carry_out; else BCD +1 (ones 9 -> 0, tens+1).
//    dec at MIN_VAL -> MAX_VAL + borrow_out; else BCD -1 (ones 0 -> 9, tens-1).
//    count_inc and count_dec together: inc wins, dec dropped.
//    set_mode=1: count_inc/count_dec ignored (time frozen while user adjusts).
//  Adjust steps wrap like counting but NEVER raise carry_out/borrow_out.
//  Outputs carry_out/borrow_out/load_err are registered: asserted the cycle after the causing request.
//  Adjust FSM (advances only when set_mode=1; set_mode=0 forces IDLE in the same cycle):
//    IDLE  : exactly one of adj_up/adj_dn = 1 -> step once that cycle, latch dir, cnt=0, -> HOLD.
//    HOLD  : on tick_en cnt++; on tick_en with cnt == HOLD_TICKS-1 -> step, cnt=0, -> REPEAT.
//    REPEAT: on tick_en cnt++; on tick_en with cnt == REPEAT_TICKS-1 -> step, cnt=0.
//    HOLD/REPEAT: latched button released, or both buttons high -> IDLE, no step.
//    Both high in IDLE: no step. A new press needs a cycle back in IDLE, so one press = one step.
//  Reset mid-operation: immediate asynchronous return to reset state; pending pulses are lost.
// TESTING
//  1 MAX=59: load 5/8, two count_inc -> 59 then 00, carry_out high 1 cycle after 2nd inc only.
//  2 MIN=1,MAX=12: at 01 count_dec -> 12 with borrow_out; load 1/3 and load 0/0 -> load_err, value kept.
//  3 set_mode=1, adj_up held, HOLD=8,REPEAT=2 at 57: 58 at press, 59 on 8th tick, 00 on 10th, no carry_out.
//  4 set_mode=1 at 30: adj_dn pulse 1 cycle -> 29 once; both buttons pressed together -> no change.
//  5 count_inc+count_dec same cycle at 09 -> 10; set_mode=1 with count_inc -> value unchanged.
//  6 resetn low mid-REPEAT at 45 -> 00 (MIN_VAL) asynchronously, FSM IDLE, all pulse outputs 0.

Source files
------------

// File: rtl/bcd_field_counter.sv
// Two-digit BCD time-field counter with wrap, carry/borrow, validated load
// and a tick-paced auto-repeat adjust FSM for the up/down buttons.
module bcd_field_counter #(
    parameter int unsigned MAX_VAL      = 59,
    parameter int unsigned MIN_VAL      = 0,
    parameter int unsigned HOLD_TICKS   = 8,
    parameter int unsigned REPEAT_TICKS = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       count_inc,
    input  logic       count_dec,
    input  logic       set_mode,
    input  logic       adj_up,
    input  logic       adj_dn,
    input  logic       tick_en,
    input  logic       load,
    input  logic [3:0] new_tens,
    input  logic [3:0] new_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry_out,
    output logic       borrow_out,
    output logic       at_max,
    output logic       load_err
);

    localparam logic [3:0] MAX_T = 4'(MAX_VAL / 10);
    localparam logic [3:0] MAX_O = 4'(MAX_VAL % 10);
    localparam logic [3:0] MIN_T = 4'(MIN_VAL / 10);
    localparam logic [3:0] MIN_O = 4'(MIN_VAL % 10);
    localparam logic [7:0] MAX8  = 8'(MAX_VAL);
    localparam logic [7:0] MIN8  = 8'(MIN_VAL);
    localparam int unsigned CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       tens_q, ones_q;
    logic [7:0]       val_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             err_q, err_d;
    logic             step, step_up, latched, at_min, load_ok;
    logic [7:0]       load_val;

    function automatic logic [7:0] bcd_up(input logic [3:0] t, input logic [3:0] o);
        if (t == MAX_T && o == MAX_O) return {MIN_T, MIN_O};
        else if (o == 4'd9)           return {t + 4'd1, 4'd0};
        else                          return {t, o + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dn(input logic [3:0] t, input logic [3:0] o);
        if (t == MIN_T && o == MIN_O) return {MAX_T, MAX_O};
        else if (o == 4'd0)           return {t - 4'd1, 4'd9};
        else                          return {t, o - 4'd1};
    endfunction

    assign at_max   = (tens_q == MAX_T) && (ones_q == MAX_O);
    assign at_min   = (tens_q == MIN_T) && (ones_q == MIN_O);
    assign load_val = ({4'd0, new_tens} * 8'd10) + {4'd0, new_ones};
    assign load_ok  = (new_tens <= 4'd9) && (new_ones <= 4'd9) &&
                      (load_val >= MIN8) && (load_val <= MAX8);
    assign latched  = dir_q ? adj_up : adj_dn;

    // Adjust FSM: one step on press, then repeats paced by tick_en.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        step_up = dir_q;
        if (!set_mode || load) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (adj_up ^ adj_dn) begin
                        step    = 1'b1;
                        step_up = adj_up;
                        dir_d   = adj_up;
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD, S_REPEAT: begin
                    if (!latched || (adj_up && adj_dn)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (tick_en) begin
                        if (cnt_q == ((state_q == S_HOLD) ? CNT_W'(HOLD_TICKS - 1)
                                                          : CNT_W'(REPEAT_TICKS - 1))) begin
                            step    = 1'b1;
                            cnt_d   = '0;
                            state_d = S_REPEAT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        val_d    = {tens_q, ones_q};
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        err_d    = 1'b0;
        if (load) begin
            if (load_ok) val_d = {new_tens, new_ones};
            else         err_d = 1'b1;
        end else if (step) begin
            val_d = step_up ? bcd_up(tens_q, ones_q) : bcd_dn(tens_q, ones_q);
        end else if (!set_mode && count_inc) begin
            val_d   = bcd_up(tens_q, ones_q);
            carry_d = at_max;
        end else if (!set_mode && count_dec) begin
            val_d    = bcd_dn(tens_q, ones_q);
            borrow_d = at_min;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
            tens_q   <= MIN_T;
            ones_q   <= MIN_O;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            tens_q   <= val_d[7:4];
            ones_q   <= val_d[3:0];
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            err_q    <= err_d;
        end
    end

    assign tens       = tens_q;
    assign ones       = ones_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign load_err   = err_q;

endmodule
